multicycle_ctr: RTL and testbench



---
 rtl/multicycle_ctr.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctr.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctr.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/execute FSM with bounded
// memory waits, sticky illegal-opcode and bus-timeout flags, and a retire pulse.
module multicycle_ctr #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       retire,
  output logic       illegal_op,
  output logic       bus_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ERR    = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, bus_timeout_q;
  logic       set_illegal, set_timeout;
  logic       in_wait_state, timed_out;

  assign in_wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  // A ready on the limit cycle still wins: the access completes, no timeout.
  assign timed_out     = in_wait_state && !mem_ready && (wait_q == TIMEOUT);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    unique case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            state_d     = ERR;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      ERR:    state_d = ERR;
      default: state_d = ERR;
    endcase

    if (timed_out) begin
      state_d     = ERR;
      set_timeout = 1'b1;
    end
  end

  // Any state change clears the counter, which covers every entry into a wait state.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (in_wait_state && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      wait_q        <= 8'd0;
      illegal_q     <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_illegal) illegal_q     <= 1'b1;
      if (set_timeout) bus_timeout_q <= 1'b1;
    end
  end

  // NOTE: the Mealy strobes are gated with rst_n so a ready memory cannot
  // load IR or PC while reset holds the FSM in FETCH.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = ALU_ADD;
    ALUSrcB     = SRCB_REG;
    retire      = 1'b0;

    unique case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready && rst_n;
        PCWrite = mem_ready && rst_n;
      end
      DECODE: ALUSrcB = SRCB_IMM4;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op  = illegal_q;
  assign bus_timeout = bus_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctr.sv
// Randomized scoreboard bench for multicycle_ctr plus directed reset, illegal
// opcode, timeout and mid-instruction reset scenarios.
module tb_multicycle_ctr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       retire, illegal_op, bus_timeout;
  logic [3:0] state;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  multicycle_ctr #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .retire(retire), .illegal_op(illegal_op), .bus_timeout(bus_timeout),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       ret;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
  } cyc_exp_t;

  typedef struct {
    int         cycles;
    logic       rw, m2r, rdst, mw, pcw, pcwc;
    logic [1:0] pcs;
  } ins_exp_t;

  cyc_exp_t cyc_q[$];
  ins_exp_t ins_q[$];
  cyc_exp_t mon_c;
  ins_exp_t mon_i;
  int       checks = 0;
  int       errors = 0;
  bit       sb_on  = 1'b0;
  int       cyc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One stimulus cycle: drive mem_ready, record what the spec says this cycle looks like.
  task automatic drive(input logic [3:0] st, input logic ret, input logic mr);
    cyc_exp_t c;
    mem_ready = mr;
    c.st  = st;
    c.ret = ret;
    c.irw = (st == 4'd0) && mr;
    c.pcw = ((st == 4'd0) && mr) || (st == 4'd9);
    c.rw  = (st == 4'd4) || (st == 4'd7);
    c.mw  = (st == 4'd5);
    cyc_q.push_back(c);
    tick();
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Reference sequencing of a whole instruction: fetch waits, decode, then the op's path.
  task automatic run_instr(input logic [5:0] op_i, input int fw, input int mw);
    ins_exp_t e;
    int body;
    e = '{cycles: 0, rw: 0, m2r: 0, rdst: 0, mw: 0, pcw: 0, pcwc: 0, pcs: 2'b00};
    case (op_i)
      OP_R:   begin body = 2;      e.rw = 1; e.rdst = 1; end
      OP_LW:  begin body = mw + 3; e.rw = 1; e.m2r = 1; end
      OP_SW:  begin body = mw + 2; e.mw = 1; end
      OP_BEQ: begin body = 1;      e.pcwc = 1; e.pcs = 2'b01; end
      default: begin body = 1;     e.pcw = 1; e.pcs = 2'b10; end
    endcase
    e.cycles = fw + 2 + body;
    ins_q.push_back(e);
    op = op_i;
    for (int i = 0; i < fw; i++) drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd1, 1'b0, rnd_bit());
    case (op_i)
      OP_R: begin
        drive(4'd6, 1'b0, rnd_bit());
        drive(4'd7, 1'b1, rnd_bit());
      end
      OP_LW: begin
        drive(4'd2, 1'b0, rnd_bit());
        for (int i = 0; i < mw; i++) drive(4'd3, 1'b0, 1'b0);
        drive(4'd3, 1'b0, 1'b1);
        drive(4'd4, 1'b1, rnd_bit());
      end
      OP_SW: begin
        drive(4'd2, 1'b0, rnd_bit());
        for (int i = 0; i < mw; i++) drive(4'd5, 1'b0, 1'b0);
        drive(4'd5, 1'b1, 1'b1);
      end
      OP_BEQ: drive(4'd8, 1'b1, rnd_bit());
      default: drive(4'd9, 1'b1, rnd_bit());
    endcase
  endtask

  // Monitor: per-cycle trace and per-instruction retire records, popped as the DUT presents them.
  always @(negedge clk) begin
    if (sb_on) begin
      if (cyc_q.size() > 0) begin
        mon_c = cyc_q.pop_front();
        check("sb_state",    state,    mon_c.st);
        check("sb_retire",   retire,   mon_c.ret);
        check("sb_irwrite",  IRWrite,  mon_c.irw);
        check("sb_pcwrite",  PCWrite,  mon_c.pcw);
        check("sb_regwrite", RegWrite, mon_c.rw);
        check("sb_memwrite", MemWrite, mon_c.mw);
      end
      check("excl_memrd_memwr", MemRead & MemWrite, 1'b0);
      check("excl_regwr_pcwr",  RegWrite & PCWrite, 1'b0);
      cyc_cnt++;
      if (retire) begin
        if (ins_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_retire: got retire=1 required no retire (t=%0t)", $time);
        end else begin
          mon_i = ins_q.pop_front();
          check("ret_cycles",   cyc_cnt,     mon_i.cycles);
          check("ret_regwrite", RegWrite,    mon_i.rw);
          check("ret_memtoreg", MemtoReg,    mon_i.m2r);
          check("ret_regdst",   RegDst,      mon_i.rdst);
          check("ret_memwrite", MemWrite,    mon_i.mw);
          check("ret_pcwrite",  PCWrite,     mon_i.pcw);
          check("ret_pcwcond",  PCWriteCond, mon_i.pcwc);
          check("ret_pcsource", PCSource,    mon_i.pcs);
        end
        cyc_cnt = 0;
      end
    end
  end

  // Leaves the bench at posedge+1 with rst_n just released: the start of FETCH cycle 1.
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    op        = OP_R;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};

    // Reset values, with a ready memory to confirm IRWrite/PCWrite stay low.
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_R;
    #2;
    check("rst_state",   state,       4'd0);
    check("rst_memread", MemRead,     1'b1);
    check("rst_irwrite", IRWrite,     1'b0);
    check("rst_pcwrite", PCWrite,     1'b0);
    check("rst_alusrcb", ALUSrcB,     2'b01);
    check("rst_iord",    IorD,        1'b0);
    check("rst_retire",  retire,      1'b0);
    check("rst_illegal", illegal_op,  1'b0);
    check("rst_timeout", bus_timeout, 1'b0);
    tick();
    check("rst_hold_state", state, 4'd0);

    // Directed sequences (R, lw with 3 waits, beq, j, sw) then random mix.
    rst_n = 1'b1;
    sb_on = 1'b1;
    cyc_cnt = 0;
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_SW, 2, 1);
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 4)], int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    sb_on = 1'b0;
    check("sb_cyc_drained", cyc_q.size(), 0);
    check("sb_ins_drained", ins_q.size(), 0);
    check("sb_no_flags", {illegal_op, bus_timeout}, 2'b00);

    // Illegal opcode: ERR after DECODE, sticky, inert until reset.
    do_reset();
    op = 6'b111111; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("ill_decode", state, 4'd1);
    tick();
    for (int k = 0; k < 6; k++) begin
      op = 6'($urandom);
      mem_ready = rnd_bit();
      @(negedge clk);
      check("ill_state",   state,      4'd10);
      check("ill_flag",    illegal_op, 1'b1);
      check("ill_retire",  retire,     1'b0);
      check("ill_ctrl", {PCWrite, MemRead, MemWrite, IRWrite, RegWrite, PCWriteCond, ALUSrcB}, 8'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("ill_cleared", illegal_op, 1'b0);
    check("ill_rst_state", state, 4'd0);

    // FETCH timeout: 16 waiting cycles, then ERR.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("to_fetch_wait", state, 4'd0);
      tick();
    end
    @(negedge clk);
    check("to_fetch_err", state, 4'd10);
    check("to_fetch_flag", bus_timeout, 1'b1);

    // Ready on the 16th cycle completes normally.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      mem_ready = (i == 16);
      tick();
    end
    @(negedge clk);
    check("to_edge_decode", state, 4'd1);
    check("to_edge_noflag", bus_timeout, 1'b0);

    // MEMRD timeout.
    do_reset();
    op = OP_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("to_memrd_wait", state, 4'd3);
      tick();
    end
    @(negedge clk);
    check("to_memrd_err", state, 4'd10);
    check("to_memrd_flag", bus_timeout, 1'b1);

    // Reset asserted mid-wait in MEMWR abandons the store at once.
    do_reset();
    op = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    check("rmw_in_memwr", state, 4'd5);
    check("rmw_memwrite", MemWrite, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rmw_drop_memwrite", MemWrite, 1'b0);
    check("rmw_state", state, 4'd0);
    check("rmw_retire", retire, 1'b0);
    check("rmw_strobes", {RegWrite, PCWrite, IRWrite}, 3'b000);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rmw_restart_fetch", state, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
